uart_cmd_wrapper: RTL and testbench
===================================

# uart_cmd_wrapper

Robot-side end of the remote command link. Deserialises 8N1 UART bytes from the remote controller, assembles each pair into one 16-bit command (high byte first), and presents it to the command processor with a ready/clear handshake. Serialises 8-bit acknowledge responses, such as the positive ack, back to the remote on TX. Sits between the RX/TX pins and the command processor at the top level.

## Interface
Parameters:
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); must be ≥ 8; simulation uses 16.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- RX  in  1  serial in from remote; asynchronous, idle high.
- TX  out  1  serial out to remote; idle high.
- cmd  out  16  last assembled command: {first byte, second byte}.
- cmd_rdy  out  1  a complete command is held in cmd.
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy.
- resp  in  8  response byte, sampled when send_resp is high.
- send_resp  in  1  single-cycle request to transmit resp.
- resp_sent  out  1  single-cycle pulse when the stop bit of the response completes.
- tx_busy  out  1  transmitter active.
- frm_err  out  1  single-cycle pulse when a received stop bit is sampled low.

## Operation
- Reset values: TX=1, cmd=0, cmd_rdy=0, resp_sent=0, tx_busy=0, frm_err=0. Receiver, transmitter, and assembly FSM all return to idle.
- RX input path:
  - RX passes through a 2-flop synchroniser and is preset high by reset.
  - A falling edge on the synchronised signal while the receiver is idle starts a frame.
- Receiver:
  - The baud counter is loaded with BAUD_DIV/2 for the start bit, then BAUD_DIV for each following bit.
  - Each sample point is at a bit centre.
  - If the start bit sampled at its centre is high, the frame is a glitch: return to idle with no output.
  - Data bits are LSB first and shifted into an 8-bit register.
  - At the stop-bit centre: stop=1 raises the internal rx_rdy for one cycle; stop=0 pulses frm_err and drops the byte.
  - The receiver returns to idle at the stop-bit centre and can detect a new start edge on the next cycle.
- Assembly FSM, states HIGH and LOW:
  - HIGH + rx_rdy: latch the byte into the high holding register, clear cmd_rdy, go to LOW.
  - LOW + rx_rdy: cmd <= {high, byte}, set cmd_rdy, go to HIGH.
  - Any frm_err returns the FSM to HIGH. A partially received command is discarded; cmd and cmd_rdy keep their values.
  - cmd is updated only when a full pair completes.
- cmd_rdy:
  - Cleared by clr_cmd_rdy.
  - Cleared by the first byte of the next command.
  - If clr_cmd_rdy and a completing second byte arrive in the same cycle, set wins.
- Transmitter:
  - send_resp while idle latches resp and sets tx_busy.
  - It sends the start bit (0), 8 data bits LSB first, then the stop bit (1), each BAUD_DIV clocks.
  - send_resp while tx_busy is ignored; there is no queue.
- Receive and transmit run fully in parallel.

## Timing
- RX latency:
  - A start edge on the pin reaches the synchroniser output 2 cycles later.
  - rx_rdy follows the synchronised edge by BAUD_DIV/2 + 9·BAUD_DIV cycles (±1).
  - cmd/cmd_rdy update on the cycle after the second byte's rx_rdy.
- TX, with send_resp sampled at edge n:
  - tx_busy=1 and TX=0 from edge n+1.
  - Each bit holds for exactly BAUD_DIV cycles.
  - The stop bit ends at edge n+1+10·BAUD_DIV; resp_sent pulses and tx_busy falls on that edge.
  - A new send_resp is accepted in that same cycle.
- Pulse widths: resp_sent and frm_err are exactly one cycle wide.
- Reset mid-operation: an asynchronous assert at any point forces TX high and clears all state immediately. Frames in flight are lost, and nothing is emitted after release until a fresh start edge or send_resp.

## Test plan
- Single command, BAUD_DIV=16:
  - Stimulus: remote sends bytes 0x4B then 0xF1.
  - Required: cmd=16'h4BF1 with cmd_rdy=1 within 1 cycle of the second stop centre; cmd_rdy stays high until clr_cmd_rdy, then goes 0 next cycle.
- Response:
  - Stimulus: pulse send_resp with resp=0xA5.
  - Required:
    - TX carries 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles wide.
    - resp_sent pulses once, 161 cycles after send_resp.
    - A second send_resp issued mid-frame produces no extra frame.
- Framing error:
  - Stimulus: send 0x12, then a byte 0x34 with stop=0, then 0x56, 0x78.
  - Required: exactly one frm_err pulse; cmd=16'h5678, never 16'h1234 or 16'h3456.
- Glitch rejection:
  - Stimulus: a 3-cycle low pulse on RX.
  - Required: no rx_rdy and FSM still in HIGH; a following 0xAB, 0xCD gives cmd=16'hABCD.
- Simultaneous events:
  - Stimulus: assert clr_cmd_rdy in the same cycle the second byte completes.
  - Required: cmd_rdy=1.
  - Stimulus: run full-duplex RX 0x0102 while TX sends 0xFF.
  - Required: both complete correctly.
- Reset mid-frame:
  - Stimulus: assert rst during bit 4 of TX and after the first RX byte.
  - Required: TX=1, tx_busy=0 and cmd_rdy=0 immediately; the next pair 0x11, 0x22 gives cmd=16'h1122.

Source files
------------

// File: rtl/uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// Module : uart_cmd_wrapper
// 8N1 UART link: byte pairs in -> 16-bit command, response byte out on TX.
// Rev    : 1.0
// ============================================================================
module uart_cmd_wrapper #(
   parameter int BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        tx_busy,
   output logic        frm_err
);

   localparam int CNT_W = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] c_half_load = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] c_full_load = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [0:0] {
      ASM_HIGH = 1'b0,
      ASM_LOW  = 1'b1
   } asm_state_t;

   typedef enum logic [0:0] {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } tx_state_t;

   // ---------------------------------------------------------------- receiver
   logic             r_rx_meta, r_rx_sync, r_rx_prev;
   rx_state_t        r_rx_state, w_rx_next;
   logic [CNT_W-1:0] r_rx_cnt;
   logic [2:0]       r_rx_bits;
   logic [7:0]       r_rx_shift;
   logic             r_rx_rdy;
   logic             w_rx_fall, w_rx_tick;

   assign w_rx_fall = r_rx_prev & ~r_rx_sync;
   assign w_rx_tick = (r_rx_cnt == '0);

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
         RX_START: if (w_rx_tick) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick && (r_rx_bits == 3'd7)) w_rx_next = RX_STOP;
         RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bits  <= '0;
         r_rx_shift <= '0;
         r_rx_rdy   <= 1'b0;
         frm_err    <= 1'b0;
      end else begin
         r_rx_meta  <= RX;
         r_rx_sync  <= r_rx_meta;
         r_rx_prev  <= r_rx_sync;
         r_rx_state <= w_rx_next;
         r_rx_rdy   <= 1'b0;
         frm_err    <= 1'b0;
         case (r_rx_state)
            // Idle keeps the half-bit load primed so the start bit is timed from the edge.
            RX_IDLE: begin
               r_rx_cnt  <= c_half_load;
               r_rx_bits <= '0;
            end
            RX_START: r_rx_cnt <= w_rx_tick ? c_full_load : r_rx_cnt - c_one;
            RX_DATA: begin
               if (w_rx_tick) begin
                  r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                  r_rx_bits  <= r_rx_bits + 3'd1;
                  r_rx_cnt   <= c_full_load;
               end else begin
                  r_rx_cnt <= r_rx_cnt - c_one;
               end
            end
            RX_STOP: begin
               if (w_rx_tick) begin
                  r_rx_rdy <= r_rx_sync;
                  frm_err  <= ~r_rx_sync;
               end else begin
                  r_rx_cnt <= r_rx_cnt - c_one;
               end
            end
            default: r_rx_cnt <= '0;
         endcase
      end
   end

   // ---------------------------------------------------------------- assembly
   asm_state_t r_asm_state, w_asm_next;
   logic [7:0] r_high;

   always_comb begin
      w_asm_next = r_asm_state;
      if (frm_err) begin
         w_asm_next = ASM_HIGH;
      end else if (r_rx_rdy) begin
         w_asm_next = (r_asm_state == ASM_HIGH) ? ASM_LOW : ASM_HIGH;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_asm_state <= ASM_HIGH;
         r_high      <= '0;
         cmd         <= '0;
         cmd_rdy     <= 1'b0;
      end else begin
         r_asm_state <= w_asm_next;
         // A completing low byte takes priority over a simultaneous clear.
         if (r_rx_rdy && (r_asm_state == ASM_HIGH)) begin
            r_high  <= r_rx_shift;
            cmd_rdy <= 1'b0;
         end else if (r_rx_rdy && (r_asm_state == ASM_LOW)) begin
            cmd     <= {r_high, r_rx_shift};
            cmd_rdy <= 1'b1;
         end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------- transmitter
   tx_state_t        r_tx_state, w_tx_next;
   logic [CNT_W-1:0] r_tx_cnt;
   logic [3:0]       r_tx_bits;
   logic [8:0]       r_tx_shift;
   logic             w_tx_tick, w_tx_last;

   assign w_tx_tick = (r_tx_cnt == '0);
   assign w_tx_last = (r_tx_bits == 4'd9);
   assign tx_busy   = (r_tx_state == TX_SEND);

   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE: if (send_resp) w_tx_next = TX_SEND;
         TX_SEND: if (w_tx_tick && w_tx_last) w_tx_next = TX_IDLE;
         default: w_tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_bits  <= '0;
         r_tx_shift <= '1;
         TX         <= 1'b1;
         resp_sent  <= 1'b0;
      end else begin
         r_tx_state <= w_tx_next;
         resp_sent  <= 1'b0;
         case (r_tx_state)
            TX_IDLE: begin
               if (send_resp) begin
                  TX         <= 1'b0;
                  r_tx_shift <= {1'b1, resp};
                  r_tx_cnt   <= c_full_load;
                  r_tx_bits  <= '0;
               end
            end
            TX_SEND: begin
               if (w_tx_tick) begin
                  if (w_tx_last) begin
                     TX        <= 1'b1;
                     resp_sent <= 1'b1;
                  end else begin
                     // Shift register carries data then the stop bit, refilled with idle 1s.
                     TX         <= r_tx_shift[0];
                     r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                     r_tx_bits  <= r_tx_bits + 4'd1;
                     r_tx_cnt   <= c_full_load;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt - c_one;
               end
            end
            default: TX <= 1'b1;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_cmd_wrapper
// Directed self-checking bench for uart_cmd_wrapper at BAUD_DIV=16.
// Rev    : 1.0
// ============================================================================
module tb_uart_cmd_wrapper;

   localparam int BAUD = 16;

   logic        clk = 1'b0;
   logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, tx_busy, frm_err;
   logic [15:0] cmd;
   logic [7:0]  resp;

   int checks   = 0;
   int errors   = 0;
   int frm_cnt  = 0;
   int sent_cnt = 0;
   int bad_cmd  = 0;

   typedef struct {
      logic [7:0]  b_hi;
      logic [7:0]  b_lo;
      logic [15:0] exp_cmd;
   } vec_t;

   vec_t vecs[5];

   uart_cmd_wrapper #(.BAUD_DIV(BAUD)) dut (
      .clk         (clk),
      .rst         (rst),
      .RX          (RX),
      .TX          (TX),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .resp        (resp),
      .send_resp   (send_resp),
      .resp_sent   (resp_sent),
      .tx_busy     (tx_busy),
      .frm_err     (frm_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frm_err) frm_cnt++;
      if (resp_sent) sent_cnt++;
      if (cmd == 16'h1234 || cmd == 16'h3456) bad_cmd++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after one idle bit time.
   task automatic uart_byte(input logic [7:0] b, input logic stop_bit);
      RX = 1'b0;
      cycles(BAUD);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         cycles(BAUD);
      end
      RX = stop_bit;
      cycles(BAUD);
      RX = 1'b1;
      cycles(BAUD);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      int         first_sent;
      int         sent0;
      int         frm0;
      int         tx_low;
      logic [9:0] a5_bits;
      logic [9:0] cap;
      logic [15:0] prev_cmd;

      a5_bits = 10'b1101001010;   // frame bit j at index j: start, A5 LSB first, stop
      vecs[0] = '{8'h00, 8'h00, 16'h0000};
      vecs[1] = '{8'hFF, 8'hFF, 16'hFFFF};
      vecs[2] = '{8'h01, 8'h80, 16'h0180};
      vecs[3] = '{8'hA5, 8'h5A, 16'hA55A};
      vecs[4] = '{8'hC3, 8'h3C, 16'hC33C};

      rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
      cycles(5);
      check("reset_tx", TX, 1);
      check("reset_tx_busy", tx_busy, 0);
      check("reset_cmd", cmd, 0);
      check("reset_cmd_rdy", cmd_rdy, 0);
      check("reset_resp_sent", resp_sent, 0);
      check("reset_frm_err", frm_err, 0);
      rst = 1'b0;
      cycles(5);

      // Single command with latency measurement on the second byte
      uart_byte(8'h4B, 1'b1);
      check("first_byte_no_rdy", cmd_rdy, 0);
      n = 0;
      fork
         uart_byte(8'hF1, 1'b1);
         begin
            while (!cmd_rdy && n < 400) begin
               @(negedge clk);
               n++;
            end
         end
      join
      check_range("rx_latency", n, 156, 158);
      check("cmd_4BF1", cmd, 16'h4BF1);
      check("rdy_4BF1", cmd_rdy, 1);
      cycles(20);
      check("rdy_holds", cmd_rdy, 1);
      clr_cmd_rdy = 1'b1;
      cycles(1);
      clr_cmd_rdy = 1'b0;
      check("rdy_cleared", cmd_rdy, 0);

      // Table of byte pairs
      prev_cmd = 16'h4BF1;
      for (int i = 0; i < 5; i++) begin
         uart_byte(vecs[i].b_hi, 1'b1);
         check("tbl_hi_rdy", cmd_rdy, 0);
         check("tbl_hi_cmd_kept", cmd, prev_cmd);
         uart_byte(vecs[i].b_lo, 1'b1);
         check("tbl_cmd", cmd, vecs[i].exp_cmd);
         check("tbl_rdy", cmd_rdy, 1);
         prev_cmd = vecs[i].exp_cmd;
      end

      // Response frame, bit widths, pulse timing, ignored second request
      sent0 = sent_cnt; first_sent = 0; tx_low = 0;
      resp = 8'hA5; send_resp = 1'b1;
      cycles(1);
      send_resp = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (c == 1) check("tx_busy_start", tx_busy, 1);
         if (c <= 160 && (c % 16 == 1 || c % 16 == 0)) check("tx_bit", TX, a5_bits[(c - 1) / 16]);
         if (c == 70) begin resp = 8'h00; send_resp = 1'b1; end
         if (c == 71) send_resp = 1'b0;
         if (resp_sent && first_sent == 0) first_sent = c;
         if (c > 161 && !TX) tx_low++;
      end
      check("resp_sent_time", first_sent, 161);
      check("resp_sent_count", sent_cnt - sent0, 1);
      check("no_extra_frame", tx_low, 0);
      check("tx_busy_end", tx_busy, 0);
      cycles(1);

      // Framing error on the low byte discards the pair
      frm0 = frm_cnt;
      uart_byte(8'h12, 1'b1);
      uart_byte(8'h34, 1'b0);
      check("frm_pulse", frm_cnt - frm0, 1);
      check("frm_cmd_kept", cmd, 16'hC33C);
      check("frm_rdy", cmd_rdy, 0);
      uart_byte(8'h56, 1'b1);
      uart_byte(8'h78, 1'b1);
      check("frm_cmd_5678", cmd, 16'h5678);
      check("frm_rdy_5678", cmd_rdy, 1);
      check("frm_pulse_total", frm_cnt - frm0, 1);
      check("no_bad_cmd", bad_cmd, 0);

      // Short low glitch must not produce a byte
      frm0 = frm_cnt;
      RX = 1'b0;
      cycles(3);
      RX = 1'b1;
      cycles(180);
      check("glitch_rdy", cmd_rdy, 1);
      check("glitch_cmd", cmd, 16'h5678);
      check("glitch_frm", frm_cnt - frm0, 0);
      uart_byte(8'hAB, 1'b1);
      check("glitch_hi_rdy", cmd_rdy, 0);
      uart_byte(8'hCD, 1'b1);
      check("glitch_cmd_ABCD", cmd, 16'hABCD);
      check("glitch_rdy_ABCD", cmd_rdy, 1);

      // Clear coincident with the completing byte: set wins
      uart_byte(8'h5A, 1'b1);
      fork
         uart_byte(8'hC3, 1'b1);
         begin
            cycles(155);
            clr_cmd_rdy = 1'b1;
            cycles(1);
            clr_cmd_rdy = 1'b0;
         end
      join
      check("simul_rdy", cmd_rdy, 1);
      check("simul_cmd", cmd, 16'h5AC3);

      // Full duplex: RX pair while TX sends 0xFF
      sent0 = sent_cnt; first_sent = 0; cap = '0;
      resp = 8'hFF; send_resp = 1'b1;
      cycles(1);
      send_resp = 1'b0;
      fork
         begin
            uart_byte(8'h01, 1'b1);
            uart_byte(8'h02, 1'b1);
         end
         begin
            for (int c = 1; c <= 170; c++) begin
               @(negedge clk);
               if (c % 16 == 8 && c < 160) cap[c / 16] = TX;
               if (resp_sent && first_sent == 0) first_sent = c;
            end
         end
      join
      check("dup_tx_frame", cap, 10'h3FE);
      check("dup_resp_time", first_sent, 161);
      check("dup_resp_count", sent_cnt - sent0, 1);
      check("dup_cmd", cmd, 16'h0102);
      check("dup_rdy", cmd_rdy, 1);

      // Asynchronous reset mid-TX and between command bytes
      uart_byte(8'h77, 1'b1);
      check("mid_hi_rdy", cmd_rdy, 0);
      resp = 8'h00; send_resp = 1'b1;
      cycles(1);
      send_resp = 1'b0;
      cycles(70);
      check("mid_tx_low", TX, 0);
      check("mid_tx_busy", tx_busy, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_tx", TX, 1);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_cmd_rdy", cmd_rdy, 0);
      check("rst_cmd", cmd, 0);
      cycles(3);
      rst = 1'b0;
      sent0 = sent_cnt; tx_low = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (!TX) tx_low++;
      end
      check("post_rst_tx_idle", tx_low, 0);
      check("post_rst_no_sent", sent_cnt - sent0, 0);
      check("post_rst_cmd", cmd, 0);
      cycles(1);
      uart_byte(8'h11, 1'b1);
      uart_byte(8'h22, 1'b1);
      check("post_rst_cmd_1122", cmd, 16'h1122);
      check("post_rst_rdy", cmd_rdy, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
